// File: rtl/flag_hazard_ctrl_if.sv
// Handshake bundle between decode, the EX/MEM/WB flag tracking and the flag register.
// The DUT connects through the slave modport; the pipeline side uses master.
interface flag_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   ID_valid;
    logic [3:0]             ID_cond;
    logic                   ID_use_c;
    logic                   EX_S;
    logic [3:0]             EX_flags;
    logic [3:0]             RF_flags;
    logic                   HOLD;
    logic                   FLUSH;
    logic                   cond_pass;
    logic                   carry_fwd;
    logic                   flag_stall;
    logic                   flag_we;
    logic [3:0]             flag_wdata;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output ID_valid, ID_cond, ID_use_c, EX_S, EX_flags, RF_flags, HOLD, FLUSH,
        input  cond_pass, carry_fwd, flag_stall, flag_we, flag_wdata, stall_cnt
    );

    modport slave (
        input  ID_valid, ID_cond, ID_use_c, EX_S, EX_flags, RF_flags, HOLD, FLUSH,
        output cond_pass, carry_fwd, flag_stall, flag_we, flag_wdata, stall_cnt
    );
endinterface

// File: rtl/flag_hazard_ctrl.sv
// Condition-code hazard controller: tracks S-bit results through MEM/WB, writes the flag
// register at WB and resolves ID conditions. Define FLAG_FWD_EN to forward instead of stall.
module flag_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 CLR,
    flag_hazard_ctrl_if.slave    bus
);
    logic                   m_v_q, m_v_d;
    logic [3:0]             m_f_q, m_f_d;
    logic                   w_v_q, w_v_d;
    logic [3:0]             w_f_q, w_f_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [3:0]             sel_flags;
    logic                   id_reads_flags;
    logic                   stall;
    logic                   pass;

    // Flag layout is {N,Z,C,V}
    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    eval_cond = z;
            4'h1:    eval_cond = ~z;
            4'h2:    eval_cond = c;
            4'h3:    eval_cond = ~c;
            4'h4:    eval_cond = n;
            4'h5:    eval_cond = ~n;
            4'h6:    eval_cond = v;
            4'h7:    eval_cond = ~v;
            4'h8:    eval_cond = c & ~z;
            4'h9:    eval_cond = ~c | z;
            4'hA:    eval_cond = (n == v);
            4'hB:    eval_cond = (n != v);
            4'hC:    eval_cond = ~z & (n == v);
            4'hD:    eval_cond = z | (n != v);
            4'hE:    eval_cond = 1'b1;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    always_comb begin
        id_reads_flags = bus.ID_valid & ((bus.ID_cond != 4'hE) | bus.ID_use_c);
`ifdef FLAG_FWD_EN
        // Youngest producer wins so back-to-back S instructions resolve correctly
        if (bus.EX_S) begin
            sel_flags = bus.EX_flags;
        end else if (m_v_q) begin
            sel_flags = m_f_q;
        end else if (w_v_q) begin
            sel_flags = w_f_q;
        end else begin
            sel_flags = bus.RF_flags;
        end
        stall = 1'b0;
`else
        sel_flags = bus.RF_flags;
        stall     = id_reads_flags & (bus.EX_S | m_v_q | w_v_q);
`endif
        pass = eval_cond(bus.ID_cond, sel_flags);
    end

    always_comb begin
        m_v_d       = m_v_q;
        m_f_d       = m_f_q;
        w_v_d       = w_v_q;
        w_f_d       = w_f_q;
        stall_cnt_d = stall_cnt_q;
        if (!bus.HOLD) begin
            m_v_d = bus.EX_S & ~bus.FLUSH;
            m_f_d = bus.EX_flags;
            w_v_d = m_v_q;
            w_f_d = m_f_q;
            if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            m_v_q       <= 1'b0;
            m_f_q       <= 4'h0;
            w_v_q       <= 1'b0;
            w_f_q       <= 4'h0;
            stall_cnt_q <= '0;
        end else begin
            m_v_q       <= m_v_d;
            m_f_q       <= m_f_d;
            w_v_q       <= w_v_d;
            w_f_q       <= w_f_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.cond_pass  = pass;
    assign bus.carry_fwd  = sel_flags[1];
    assign bus.flag_stall = stall;
    assign bus.flag_we    = w_v_q;
    assign bus.flag_wdata = w_f_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Directed bench for flag_hazard_ctrl; expectations follow the FLAG_FWD_EN setting of the build.
module tb_flag_hazard_ctrl;
    localparam int CW = 4;

    logic CLK;
    logic CLR;
    int   checks;
    int   failures;

    flag_hazard_ctrl_if #(.STALL_CNT_W(CW)) bus ();

    flag_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge, then let inputs be driven
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        CLR = 1'b0;
        tick();
        CLR = 1'b1;
    endtask

    initial begin
        logic [15:0] pass_tbl;
        logic [CW-1:0] ones;
        checks       = 0;
        failures     = 0;
        pass_tbl     = 16'h6A9A;
        ones         = '1;
        CLR          = 1'b0;
        bus.ID_valid = 1'b0;
        bus.ID_cond  = 4'hE;
        bus.ID_use_c = 1'b0;
        bus.EX_S     = 1'b0;
        bus.EX_flags = 4'h0;
        bus.RF_flags = 4'h0;
        bus.HOLD     = 1'b0;
        bus.FLUSH    = 1'b0;

        // Reset with an S instruction present during reset
        #1;
        bus.EX_S = 1'b1; bus.EX_flags = 4'hF;
        tick(); tick();
        CLR = 1'b1; bus.EX_S = 1'b0; settle();
        check("rst_we", 16'(bus.flag_we), 16'h0);
        check("rst_wdata", 16'(bus.flag_wdata), 16'h0);
        check("rst_cnt", 16'(bus.stall_cnt), 16'h0);
        check("rst_stall", 16'(bus.flag_stall), 16'h0);
        tick(); settle();
        check("rst_we_c2", 16'(bus.flag_we), 16'h0);

        // Write latency: visible at cycle 2 only
        do_reset();
        bus.EX_S = 1'b1; bus.EX_flags = 4'b0100; settle();
        check("lat_c0_we", 16'(bus.flag_we), 16'h0);
        tick(); bus.EX_S = 1'b0; bus.EX_flags = 4'h0; settle();
        check("lat_c1_we", 16'(bus.flag_we), 16'h0);
        tick(); settle();
        check("lat_c2_we", 16'(bus.flag_we), 16'h1);
        check("lat_c2_wdata", 16'(bus.flag_wdata), 16'h4);
        tick(); settle();
        check("lat_c3_we", 16'(bus.flag_we), 16'h0);

        // FLUSH squashes the EX entry
        do_reset();
        bus.EX_S = 1'b1; bus.EX_flags = 4'hF; bus.FLUSH = 1'b1;
        tick(); bus.EX_S = 1'b0; bus.FLUSH = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("flush_we_c%0d", i + 1), 16'(bus.flag_we), 16'h0);
            tick();
        end

        // HOLD freezes the WB entry; a new EX_S during HOLD is ignored
        do_reset();
        bus.EX_S = 1'b1; bus.EX_flags = 4'b0011;
        tick(); bus.EX_S = 1'b0; bus.EX_flags = 4'h0;
        tick(); bus.HOLD = 1'b1; settle();
        check("hold_c2_we", 16'(bus.flag_we), 16'h1);
        check("hold_c2_wdata", 16'(bus.flag_wdata), 16'h3);
        tick(); bus.EX_S = 1'b1; bus.EX_flags = 4'hF; settle();
        check("hold_c3_we", 16'(bus.flag_we), 16'h1);
        check("hold_c3_wdata", 16'(bus.flag_wdata), 16'h3);
        tick(); bus.HOLD = 1'b0; bus.EX_S = 1'b0; bus.EX_flags = 4'h0; settle();
        check("hold_c4_we", 16'(bus.flag_we), 16'h1);
        check("hold_c4_wdata", 16'(bus.flag_wdata), 16'h3);
        tick(); settle();
        check("hold_c5_we", 16'(bus.flag_we), 16'h0);

        // Reset mid-flight wins over HOLD and drops the pending write
        do_reset();
        bus.EX_S = 1'b1; bus.EX_flags = 4'b0110;
        tick(); bus.EX_S = 1'b0; CLR = 1'b0; bus.HOLD = 1'b1;
        tick(); CLR = 1'b1; bus.HOLD = 1'b0; settle();
        check("midrst_c2_we", 16'(bus.flag_we), 16'h0);
        check("midrst_c2_wdata", 16'(bus.flag_wdata), 16'h0);
        tick(); settle();
        check("midrst_c3_we", 16'(bus.flag_we), 16'h0);

        // Condition table on RF flags N=1 Z=0 C=0 V=0, idle pipe
        do_reset();
        bus.RF_flags = 4'b1000; bus.ID_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            bus.ID_cond = 4'(c); settle();
            check($sformatf("cond_%0h", c), 16'(bus.cond_pass), 16'(pass_tbl[c]));
        end
        check("carry_rf0", 16'(bus.carry_fwd), 16'h0);
        bus.RF_flags = 4'b0010; settle();
        check("carry_rf1", 16'(bus.carry_fwd), 16'h1);

        // Which instructions read flags
        bus.EX_S = 1'b1; bus.EX_flags = 4'h0; bus.ID_cond = 4'hE; bus.ID_use_c = 1'b0; settle();
        check("reads_al", 16'(bus.flag_stall), 16'h0);
        bus.ID_use_c = 1'b1; settle();
`ifdef FLAG_FWD_EN
        check("reads_al_usec", 16'(bus.flag_stall), 16'h0);
        check("carry_fwd_ex", 16'(bus.carry_fwd), 16'h0);
`else
        check("reads_al_usec", 16'(bus.flag_stall), 16'h1);
        check("carry_rf_stall", 16'(bus.carry_fwd), 16'h1);
`endif
        bus.ID_valid = 1'b0; settle();
        check("reads_novalid", 16'(bus.flag_stall), 16'h0);
        bus.EX_S = 1'b0; bus.ID_use_c = 1'b0;

        // Forward priority: EX over MEM over WB over RF
        do_reset();
        bus.RF_flags = 4'b0100;
        bus.EX_S = 1'b1; bus.EX_flags = 4'b0100;
        tick(); bus.EX_flags = 4'b0000; bus.ID_valid = 1'b1; bus.ID_cond = 4'h0; settle();
`ifdef FLAG_FWD_EN
        check("fwd_ex_pass", 16'(bus.cond_pass), 16'h0);
        check("fwd_ex_stall", 16'(bus.flag_stall), 16'h0);
`else
        check("fwd_ex_pass", 16'(bus.cond_pass), 16'h1);
        check("fwd_ex_stall", 16'(bus.flag_stall), 16'h1);
`endif
        tick(); bus.EX_S = 1'b0; settle();
`ifdef FLAG_FWD_EN
        check("fwd_mem_pass", 16'(bus.cond_pass), 16'h0);
`else
        check("fwd_mem_pass", 16'(bus.cond_pass), 16'h1);
`endif
        bus.ID_valid = 1'b0;

        // Stall window: S in EX at cycle 1, dependent NE in ID from cycle 1
        do_reset();
        settle();
        check("stl_c0", 16'(bus.flag_stall), 16'h0);
        tick(); bus.EX_S = 1'b1; bus.EX_flags = 4'h0; bus.ID_valid = 1'b1; bus.ID_cond = 4'h1;
        for (int i = 1; i <= 3; i++) begin
            settle();
`ifdef FLAG_FWD_EN
            check($sformatf("stl_c%0d", i), 16'(bus.flag_stall), 16'h0);
`else
            check($sformatf("stl_c%0d", i), 16'(bus.flag_stall), 16'h1);
`endif
            tick(); bus.EX_S = 1'b0;
        end
        settle();
        check("stl_c4", 16'(bus.flag_stall), 16'h0);
`ifdef FLAG_FWD_EN
        check("stl_cnt", 16'(bus.stall_cnt), 16'h0);
`else
        check("stl_cnt", 16'(bus.stall_cnt), 16'h3);
`endif

        // Counter freezes under HOLD and saturates at all-ones
        do_reset();
        bus.EX_S = 1'b1; bus.ID_valid = 1'b1; bus.ID_cond = 4'h0; bus.HOLD = 1'b1;
        tick(); tick(); settle();
        check("cnt_hold", 16'(bus.stall_cnt), 16'h0);
        bus.HOLD = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        settle();
`ifdef FLAG_FWD_EN
        check("cnt_sat", 16'(bus.stall_cnt), 16'h0);
`else
        check("cnt_sat", 16'(bus.stall_cnt), 16'(ones));
`endif
        bus.EX_S = 1'b0; bus.ID_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/flag_hazard_ctrl.md
# flag_hazard_ctrl

Condition-code controller between the decode stage and the flag register. It tracks flag-setting (S-bit) instructions from EX through MEM and WB, and drives the flag register's write strobe and data at WB. It resolves the condition field of the instruction in ID against the youngest in-flight flags, either by forwarding or by stalling ID. It also counts flag-hazard stall cycles for performance monitoring.

## Interface
- STALL_CNT_W, 16, width of the saturating stall-cycle counter
- CLK  in  1  clock; all state updates on rising edge
- CLR  in  1  reset; one clock; reset is synchronous and active-low
- ID_valid  in  1  valid instruction in ID
- ID_cond  in  4  ARM condition field of the ID instruction
- ID_use_c  in  1  ID instruction consumes carry as an operand (ADC/SBC/RSC/RRX)
- EX_S  in  1  EX instruction is valid and sets flags
- EX_flags  in  4  ALU flags from EX, {N,Z,C,V}
- RF_flags  in  4  architectural flags from the flag register, {N,Z,C,V}
- HOLD  in  1  global pipeline freeze; internal stage registers keep their values
- FLUSH  in  1  squash the EX-stage entry at this edge
- cond_pass  out  1  ID condition evaluates true on the selected flags
- carry_fwd  out  1  selected C flag, for the ALU carry-in of ID_use_c instructions
- flag_stall  out  1  ID must hold; EX receives a bubble
- flag_we  out  1  write strobe to the flag register (its S input)
- flag_wdata  out  4  data to the flag register, {N,Z,C,V}
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with flag_stall=1

## Operation
- Internal stage registers:
  - m_v/m_f: MEM entry.
  - w_v/w_f: WB entry.
- Shift at each edge when CLR=1 and HOLD=0:
  - m_v<=EX_S&~FLUSH, m_f<=EX_flags.
  - w_v<=m_v, w_f<=m_f.
- HOLD=1 keeps m_v, m_f, w_v and w_f unchanged. FLUSH has no effect while HOLD=1.
- flag_we=w_v, flag_wdata=w_f, both combinational from the WB registers. While HOLD=1 the same WB entry is written again each cycle; this is idempotent and allowed.
- Flag selection for ID, highest priority first: EX (EX_S=1) > MEM (m_v) > WB (w_v) > RF_flags. The selected value drives cond_pass and carry_fwd.
- Flags read flags, so ID reads flags when ID_valid=1 and (ID_cond!=4'hE or ID_use_c=1).
- Condition decode uses the standard ARM table: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
  - 4'hE (AL) evaluates true.
  - 4'hF evaluates false.
- flag_stall is defined under Configuration.
- stall_cnt increments by 1 on each edge where flag_stall=1 and HOLD=0. It saturates at all-ones.

## Timing
- Reset (CLR=0 at an edge) sets m_v=w_v=0, m_f=w_f=0 and stall_cnt=0. After that edge:
  - flag_we=0, flag_wdata=0.
  - flag_stall=0 unless EX_S=1.
  - cond_pass/carry_fwd follow RF_flags.
- Reset mid-operation discards all in-flight entries; the pending flag writes never occur. CLR has priority over HOLD and FLUSH.
- Latency: flags presented with EX_S at cycle t appear on flag_we/flag_wdata at cycle t+2, assuming no HOLD. The flag register updates at the edge that ends cycle t+2.
- FLUSH together with EX_S=1 gives m_v=0 at the next edge. MEM and WB entries are unaffected.
- Back-to-back S instructions occupy EX, MEM and WB together. The younger entry always wins selection.
- cond_pass, carry_fwd and flag_stall are purely combinational from current inputs and state. No registered outputs except the state-derived ones.

## Configuration
- Macro FLAG_FWD_EN.
- Defined:
  - Forwarding per the priority above.
  - flag_stall is constant 0.
- Undefined:
  - Selection always uses RF_flags.
  - flag_stall = ID reads flags & (EX_S|m_v|w_v).
  - cond_pass/carry_fwd are meaningful only when flag_stall=0.
  - A dependent instruction behind a fresh S instruction stalls exactly 3 cycles, assuming no HOLD.

## Test plan
- Reset: CLR=0 for 2 cycles with EX_S=1 and EX_flags=4'hF, then release -> flag_we=0, flag_wdata=0, stall_cnt=0 on the first cycle after release.
- Write latency: EX_S=1 with EX_flags=4'b0100 at cycle 0, then EX_S=0 -> flag_we=1 and flag_wdata=4'b0100 at cycle 2 only.
- Forward priority (FLAG_FWD_EN): MEM holds Z=1, EX presents Z=0 with EX_S=1, ID_cond=EQ -> cond_pass=0. Next cycle with EX_S=0 -> cond_pass=0 (the MEM entry now holds Z=0).
- Stall mode (no FLAG_FWD_EN): S instruction at cycle 0, ID_cond=NE with ID_valid=1 from cycle 1 -> flag_stall=1 for cycles 1–3, 0 at cycle 4; stall_cnt=3.
- FLUSH and HOLD:
  - EX_S=1 with FLUSH=1 -> flag_we stays 0 for the following 3 cycles.
  - HOLD=1 for 2 cycles with w_v=1 -> flag_we=1 on each of those cycles and w_f unchanged.
- Condition table: RF_flags N=1, V=0, Z=0, idle pipe; sweep ID_cond 0..F -> pass for NE, MI, CC, VC, LS, LT, LE, AL, and fail for all other codes, including 4'hF.
